except_sequencer: RTL

- Multi-cycle controller that executes the single-cycle exception decision produced by the exception unit in the memory stage.
- Captures an exception/eret request and freezes the pipeline.
- Waits for any outstanding data-bus transaction to drain, then commits the CP0 side effects (EPC, Cause, BadVAddr, Status.EXL/ERL) in one pulse.
- Finally issues the PC redirect together with a full-pipeline flush.

---
 rtl/except_sequencer_pkg.sv | 48 ++++
 rtl/except_sequencer_drain_timer.sv | 34 +++
 rtl/except_sequencer.sv | 139 +++++++++++++
 3 files changed

// File: rtl/except_sequencer_pkg.sv
// Shared types for the exception sequencer: ExcCodes, sequencer state,
// captured request and the bundled CP0 update.
package except_defs;

   localparam logic [4:0] EXC_CODE_INT        = 5'd0;
   localparam logic [4:0] EXC_CODE_MOD        = 5'd1;
   localparam logic [4:0] EXC_CODE_TLB_LOAD   = 5'd2;
   localparam logic [4:0] EXC_CODE_TLB_STORE  = 5'd3;
   localparam logic [4:0] EXC_CODE_ADDE_LOAD  = 5'd4;
   localparam logic [4:0] EXC_CODE_ADDE_STORE = 5'd5;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DRAIN,
      ST_COMMIT,
      ST_REDIRECT
   } Except_seq_state_t;

   typedef struct packed {
      logic        eret;
      logic [4:0]  code;
      logic        delayslot;
      logic [31:0] current_pc;
      logic [31:0] jump_pc;
      logic [31:0] extra;
      logic        erl;
   } Except_capture_t;

   typedef struct packed {
      logic        commit;
      logic [31:0] epc;
      logic        cause_bd;
      logic [4:0]  cause_exccode;
      logic        badvaddr_we;
      logic [31:0] badvaddr;
      logic        exl_set;
      logic        exl_clr;
      logic        erl_clr;
   } CP0_commit_t;

   // Address-related exceptions are the only ones that report a bad address.
   function automatic logic code_has_badvaddr(input logic [4:0] code);
      return (code == EXC_CODE_MOD)       || (code == EXC_CODE_TLB_LOAD)  ||
             (code == EXC_CODE_TLB_STORE) || (code == EXC_CODE_ADDE_LOAD) ||
             (code == EXC_CODE_ADDE_STORE);
   endfunction

endpackage

// File: rtl/except_sequencer_drain_timer.sv
// Up-counter bounding the time spent waiting for the data bus to drain.
module except_drain_timer #(
   parameter int TIMEOUT = 15
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic tc
);

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] TC_VAL = CW'(TIMEOUT - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr)
         cnt_d = '0;
      else if (en)
         cnt_d = cnt_q + CW'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign tc = (cnt_q == TC_VAL);

endmodule

// File: rtl/except_sequencer.sv
// Executes a captured exception/ERET: freeze, drain the data bus, commit CP0
// side effects in one strobe, then redirect the PC with a full flush.
//
// state    | meaning
// IDLE     | no sequence in flight; stall follows req_flush
// DRAIN    | waiting for mem_busy to fall or the drain timer to expire
// COMMIT   | one-cycle CP0 update strobe
// REDIRECT | one-cycle PC redirect with all stages flushed
module except_sequencer
   import except_defs::*;
#(
   parameter int N_STAGES      = 5,
   parameter int DRAIN_TIMEOUT = 15
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                req_flush,
   input  logic                req_eret,
   input  logic [4:0]          req_code,
   input  logic                req_delayslot,
   input  logic [31:0]         req_current_pc,
   input  logic [31:0]         req_jump_pc,
   input  logic [31:0]         req_extra,
   input  logic                status_erl,
   input  logic                mem_busy,
   output logic                stall_all,
   output logic [N_STAGES-1:0] flush,
   output logic                cp0_commit,
   output logic [31:0]         cp0_epc,
   output logic                cp0_cause_bd,
   output logic [4:0]          cp0_cause_exccode,
   output logic                cp0_badvaddr_we,
   output logic [31:0]         cp0_badvaddr,
   output logic                cp0_exl_set,
   output logic                cp0_exl_clr,
   output logic                cp0_erl_clr,
   output logic                pc_redirect,
   output logic [31:0]         pc_target,
   output logic                drain_timeout,
   output logic                busy
);

   Except_seq_state_t state_q, state_d;
   Except_capture_t   cap_q, cap_d;
   CP0_commit_t       cp0_s;
   logic              timer_clr, timer_en, timer_tc;

   except_drain_timer #(.TIMEOUT(DRAIN_TIMEOUT)) u_drain_timer (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (timer_clr),
      .en    (timer_en),
      .tc    (timer_tc)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cap_q   <= '0;
      end else begin
         state_q <= state_d;
         cap_q   <= cap_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      cap_d         = cap_q;
      timer_clr     = 1'b0;
      timer_en      = 1'b0;
      stall_all     = 1'b1;
      flush         = '0;
      cp0_s         = '0;
      pc_redirect   = 1'b0;
      pc_target     = '0;
      drain_timeout = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            // Gated so that every output reads 0 while reset is held.
            stall_all = req_flush & rst_n;
            if (req_flush) begin
               cap_d.eret       = req_eret;
               cap_d.code       = req_code;
               cap_d.delayslot  = req_delayslot;
               cap_d.current_pc = req_current_pc;
               cap_d.jump_pc    = req_jump_pc;
               cap_d.extra      = req_extra;
               cap_d.erl        = status_erl;
               timer_clr        = 1'b1;
               state_d          = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            timer_en = 1'b1;
            if (!mem_busy) begin
               state_d = ST_COMMIT;
            end else if (timer_tc) begin
               drain_timeout = 1'b1;
               state_d       = ST_COMMIT;
            end
         end
         ST_COMMIT: begin
            cp0_s.commit = 1'b1;
            if (cap_q.eret) begin
               cp0_s.erl_clr = cap_q.erl;
               cp0_s.exl_clr = ~cap_q.erl;
            end else begin
               cp0_s.epc           = cap_q.delayslot ? cap_q.current_pc - 32'd4
                                                     : cap_q.current_pc;
               cp0_s.cause_bd      = cap_q.delayslot;
               cp0_s.cause_exccode = cap_q.code;
               cp0_s.badvaddr_we   = code_has_badvaddr(cap_q.code);
               cp0_s.badvaddr      = cap_q.extra;
               cp0_s.exl_set       = 1'b1;
            end
            state_d = ST_REDIRECT;
         end
         ST_REDIRECT: begin
            pc_redirect = 1'b1;
            pc_target   = cap_q.jump_pc;
            flush       = '1;
            state_d     = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign cp0_commit        = cp0_s.commit;
   assign cp0_epc           = cp0_s.epc;
   assign cp0_cause_bd      = cp0_s.cause_bd;
   assign cp0_cause_exccode = cp0_s.cause_exccode;
   assign cp0_badvaddr_we   = cp0_s.badvaddr_we;
   assign cp0_badvaddr      = cp0_s.badvaddr;
   assign cp0_exl_set       = cp0_s.exl_set;
   assign cp0_exl_clr       = cp0_s.exl_clr;
   assign cp0_erl_clr       = cp0_s.erl_clr;
   assign busy              = (state_q != ST_IDLE);

endmodule
